bin_pack16: RTL and testbench

Packs the 1-bit edge stream from the Sobel stage into 16-bit words for the frame-buffer writer. Takes one binary pixel per `din_vld` beat with packet framing (`din_sop`/`din_eop`). Emits one word per 16 accepted pixels and keeps packet framing on the word stream. Sits directly downstream of the Sobel detector and upstream of the SDRAM write-side FIFO.

---
 rtl/bin_pack16_if.sv | 23 ++
 rtl/bin_pack16.sv | 123 ++++++++++++
 tb/tb_bin_pack16.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/bin_pack16_if.sv
// Pixel-in / word-out stream bundle for bin_pack16.
// The slave modport is the packer side and the master modport is the source/sink side.
interface bin_pack16_if;
  logic        din;
  logic        din_vld;
  logic        din_sop;
  logic        din_eop;
  logic [15:0] dout;
  logic        dout_vld;
  logic        dout_sop;
  logic        dout_eop;
  logic        frame_err;

  modport master (
    output din, din_vld, din_sop, din_eop,
    input  dout, dout_vld, dout_sop, dout_eop, frame_err
  );

  modport slave (
    input  din, din_vld, din_sop, din_eop,
    output dout, dout_vld, dout_sop, dout_eop, frame_err
  );
endinterface

// File: rtl/bin_pack16.sv
// Packs a framed 1-bit pixel stream into 16-bit words, MSB first.
// Optional frame-length checker enabled by defining BIN_PACK_FRAME_CHECK_EN.
module bin_pack16 #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  bin_pack16_if.slave bus
);

  typedef enum logic {IDLE, PACK} state_t;

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [15:0] shreg;
  logic [15:0] word_nxt;
  logic [15:0] sop_word;
  logic        first_word;

  // Pixel k of a word lands at bit 15-k; ~bit_cnt is that index.
  always_comb begin
    word_nxt            = shreg;
    word_nxt[~bit_cnt]  = bus.din;
    sop_word            = {bus.din, 15'h0000};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= 4'd0;
      shreg        <= 16'h0000;
      first_word   <= 1'b0;
      bus.dout     <= 16'h0000;
      bus.dout_vld <= 1'b0;
      bus.dout_sop <= 1'b0;
      bus.dout_eop <= 1'b0;
    end else begin
      bus.dout_vld <= 1'b0;
      bus.dout_sop <= 1'b0;
      bus.dout_eop <= 1'b0;
      if (bus.din_vld) begin
        if (bus.din_sop) begin
          // sop always restarts packing, discarding any partial word
          if (bus.din_eop) begin
            bus.dout     <= sop_word;
            bus.dout_vld <= 1'b1;
            bus.dout_sop <= 1'b1;
            bus.dout_eop <= 1'b1;
            state        <= IDLE;
            bit_cnt      <= 4'd0;
            shreg        <= 16'h0000;
            first_word   <= 1'b0;
          end else begin
            state        <= PACK;
            bit_cnt      <= 4'd1;
            shreg        <= sop_word;
            first_word   <= 1'b1;
          end
        end else if (state == PACK) begin
          if (bit_cnt == 4'd15 || bus.din_eop) begin
            bus.dout     <= word_nxt;
            bus.dout_vld <= 1'b1;
            bus.dout_sop <= first_word;
            bus.dout_eop <= bus.din_eop;
            first_word   <= 1'b0;
            shreg        <= 16'h0000;
            bit_cnt      <= 4'd0;
          end else begin
            shreg        <= word_nxt;
            bit_cnt      <= bit_cnt + 4'd1;
          end
          if (bus.din_eop) begin
            state <= IDLE;
          end
        end
      end
    end
  end

`ifdef BIN_PACK_FRAME_CHECK_EN
  localparam logic [18:0] FRAME_PIX = 19'(IMG_W * IMG_H);

  logic [18:0] pix_cnt;
  logic [18:0] pix_cnt_nxt;
  logic        err_q;
  logic        in_frame_beat;

  always_comb begin
    in_frame_beat = bus.din_vld & (bus.din_sop | (state == PACK));
    if (bus.din_sop) begin
      pix_cnt_nxt = 19'd1;
    end else if (pix_cnt == 19'h7FFFF) begin
      pix_cnt_nxt = pix_cnt;
    end else begin
      pix_cnt_nxt = pix_cnt + 19'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt <= 19'd0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (in_frame_beat) begin
        pix_cnt <= pix_cnt_nxt;
        if (bus.din_sop && state == PACK) begin
          err_q <= 1'b1;
        end
        if (bus.din_eop && pix_cnt_nxt != FRAME_PIX) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.frame_err = err_q;
`else
  assign bus.frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_bin_pack16.sv
// Directed, table-driven bench for bin_pack16 with a shrunk 64x8 frame.
module tb_bin_pack16;

  localparam int W = 64;
  localparam int H = 8;
  localparam int NWORDS = (W * H) / 16;
`ifdef BIN_PACK_FRAME_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    bit          din, vld, sop, eop;
    bit          e_vld, e_sop, e_eop, e_err;
    logic [15:0] e_dout;
  } vec_t;

  logic clk;
  logic rst_n;
  bin_pack16_if bus ();

  bin_pack16 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  int   words;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic push(input bit d, v, s, e, input bit ev, es, ee, input logic [15:0] ed, input bit er);
    vec_t t;
    t.din = d; t.vld = v; t.sop = s; t.eop = e;
    t.e_vld = ev; t.e_sop = es; t.e_eop = ee; t.e_dout = ed; t.e_err = er;
    vecs.push_back(t);
  endtask

  task automatic drive(input bit d, v, s, e);
    bus.din = d; bus.din_vld = v; bus.din_sop = s; bus.din_eop = e;
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic full_frame_cycle();
    tick();
    if (bus.dout_vld) begin
      check("full_dout", bus.dout, 16'hFFFF);
      check("full_sop", 16'(bus.dout_sop), 16'(words == 0));
      check("full_eop", 16'(bus.dout_eop), 16'(words == NWORDS - 1));
      check("full_err", 16'(bus.frame_err), 16'h0);
      words++;
    end else if (bus.dout_sop || bus.dout_eop || bus.frame_err) begin
      check("full_spurious_flag", {13'h0, bus.dout_sop, bus.dout_eop, bus.frame_err}, 16'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0);

    // 16-pixel alternating frame -> 0xAAAA with sop and eop
    for (int i = 0; i < 16; i++)
      push(i % 2 == 0, 1, i == 0, i == 15, i == 15, i == 15, i == 15, 16'hAAAA, (i == 15) && ERR_EN);
    // framing inputs are ignored without din_vld
    push(1, 0, 1, 1, 0, 0, 0, 16'h0, 0);
    // 20 ones -> 0xFFFF (sop), gap mid-word, then 0xF000 (eop)
    for (int i = 0; i < 20; i++) begin
      push(1, 1, i == 0, i == 19, i == 15 || i == 19, i == 15, i == 19,
           (i == 15) ? 16'hFFFF : 16'hF000, (i == 19) && ERR_EN);
      if (i == 17) push(0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    end
    // eop while idle is ignored
    push(1, 1, 0, 1, 0, 0, 0, 16'h0, 0);
    // one-pixel frame
    push(1, 1, 1, 1, 1, 1, 1, 16'h8000, ERR_EN);
    // abort after 10 pixels, then a 16-pixel frame of zeros
    for (int i = 0; i < 10; i++)
      push(1, 1, i == 0, 0, 0, 0, 0, 16'h0, 0);
    for (int i = 0; i < 16; i++)
      push(0, 1, i == 0, i == 15, i == 15, i == 15, i == 15, 16'h0000, (i == 0 || i == 15) && ERR_EN);

    #23;
    check("rst_dout", bus.dout, 16'h0000);
    check("rst_vld", 16'(bus.dout_vld), 16'h0);
    check("rst_sop", 16'(bus.dout_sop), 16'h0);
    check("rst_eop", 16'(bus.dout_eop), 16'h0);
    check("rst_err", 16'(bus.frame_err), 16'h0);
    tick();
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].din, vecs[k].vld, vecs[k].sop, vecs[k].eop);
      tick();
      check($sformatf("v%0d_vld", k), 16'(bus.dout_vld), 16'(vecs[k].e_vld));
      check($sformatf("v%0d_sop", k), 16'(bus.dout_sop), 16'(vecs[k].e_sop));
      check($sformatf("v%0d_eop", k), 16'(bus.dout_eop), 16'(vecs[k].e_eop));
      check($sformatf("v%0d_err", k), 16'(bus.frame_err), 16'(vecs[k].e_err));
      if (vecs[k].e_vld) check($sformatf("v%0d_dout", k), bus.dout, vecs[k].e_dout);
    end
    drive(0, 0, 0, 0);
    tick();

    // full-length frame of ones with random valid gaps
    words = 0;
    for (int p = 0; p < W * H; p++) begin
      drive(0, 0, 0, 0);
      repeat ($urandom_range(0, 3)) full_frame_cycle();
      drive(1, 1, p == 0, p == W * H - 1);
      full_frame_cycle();
    end
    drive(0, 0, 0, 0);
    full_frame_cycle();
    check("full_word_count", 16'(words), 16'(NWORDS));

    // reset mid-frame after 8 pixels
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, i == 0, 0);
      tick();
    end
    drive(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dout", bus.dout, 16'h0000);
    check("midrst_flags", {12'h0, bus.dout_vld, bus.dout_sop, bus.dout_eop, bus.frame_err}, 16'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, i == 4);
      tick();
      check("postrst_ignored", {12'h0, bus.dout_vld, bus.dout_sop, bus.dout_eop, bus.frame_err}, 16'h0);
    end
    for (int i = 0; i < 16; i++) begin
      drive(i == 0, 1, i == 0, i == 15);
      tick();
      check("postrst_vld", 16'(bus.dout_vld), 16'(i == 15));
    end
    check("postrst_dout", bus.dout, 16'h8000);
    check("postrst_sop_eop", {14'h0, bus.dout_sop, bus.dout_eop}, 16'h3);
    check("postrst_err", 16'(bus.frame_err), 16'(ERR_EN));
    drive(0, 0, 0, 0);
    tick();
    check("postrst_vld_drop", 16'(bus.dout_vld), 16'h0);
    check("dout_hold", bus.dout, 16'h8000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
